// File: rtl/lut_cluster_pkg.sv
// Shared types and sizing helpers for the serially configured LUT cluster.
package lut_cluster_pkg;

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    function automatic int slice_w(input int k);
        return (32'sd1 << k) + 32'sd1;
    endfunction

    function automatic int cfg_w(input int k, input int n);
        return n * slice_w(k);
    endfunction

    function automatic int cnt_w(input int k, input int n);
        return $clog2(cfg_w(k, n) + 32'sd1);
    endfunction

endpackage

// File: rtl/lut_cell.sv
// One K-input LUT; slice MSB selects combinational (0) or registered (1) output.
module lut_cell
    import lut_cluster_pkg::*;
#(
    parameter int K = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          active,
    input  logic [2**K:0] slice,
    input  logic [K-1:0]  lut_in,
    output logic          lut_out
);

    localparam int TT_W = 2**K;

    logic [TT_W-1:0] tt_s;
    logic            sel_s;
    logic            out_r;

    // truth-table lookup
    always_comb begin
        tt_s  = slice[TT_W-1:0];
        sel_s = tt_s[lut_in];
    end

    // output flop is held clear until the cluster is active
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_r <= 1'b0;
        end else if (active) begin
            out_r <= sel_s;
        end else begin
            out_r <= 1'b0;
        end
    end

    // mode select
    always_comb begin
        lut_out = 1'b0;
        if (!active) begin
            lut_out = 1'b0;
        end else if (slice[TT_W]) begin
            lut_out = out_r;
        end else begin
            lut_out = sel_s;
        end
    end

endmodule

// File: rtl/lut_cluster.sv
// N-LUT cluster loaded through a serial shift chain.
// Optional readback of the shifted-out chain bit: define LUT_CLUSTER_READBACK_EN.
module lut_cluster
    import lut_cluster_pkg::*;
#(
    parameter int K = 5,
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           cfg_start,
    input  logic           cfg_valid,
    input  logic           cfg_bit,
    output logic           cfg_ready,
    output logic           cfg_done,
    output logic           cfg_out,
    input  logic [N*K-1:0] lut_in,
    output logic [N-1:0]   lut_out
);

    localparam int SLICE_W = slice_w(K);
    localparam int CFG_W   = cfg_w(K, N);
    localparam int CNT_W   = cnt_w(K, N);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CFG_W-1:0]   chain_r;
    logic               ready_r;
    logic               done_r;
    logic               xfer_s;
    logic               active_s;

    // a start pulse wins over a same-cycle bit
    always_comb begin
        xfer_s   = cfg_valid && ready_r && !cfg_start;
        active_s = (state_r == ACTIVE);
    end

    // load FSM, shift chain and bit counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= UNCONF;
            cnt_r   <= '0;
            chain_r <= '0;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                UNCONF, ACTIVE: begin
                    if (cfg_start) begin
                        state_r <= LOAD;
                        cnt_r   <= '0;
                        ready_r <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        cnt_r <= '0;
                    end else if (xfer_s) begin
                        chain_r <= {cfg_bit, chain_r[CFG_W-1:1]};
                        cnt_r   <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(CFG_W - 1)) begin
                            state_r <= ACTIVE;
                            ready_r <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= UNCONF;
                    cnt_r   <= '0;
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = ready_r;
    assign cfg_done  = done_r;

`ifdef LUT_CLUSTER_READBACK_EN
    logic rb_r;

    // capture the bit leaving the chain so the old image streams out during a reload
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rb_r <= 1'b0;
        end else if (xfer_s) begin
            rb_r <= chain_r[0];
        end else begin
            rb_r <= rb_r;
        end
    end

    assign cfg_out = rb_r;
`else
    assign cfg_out = 1'b0;
`endif

    for (genvar j = 0; j < N; j++) begin : g_cell
        lut_cell #(.K(K)) u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .active  (active_s),
            .slice   (chain_r[j*SLICE_W +: SLICE_W]),
            .lut_in  (lut_in[j*K +: K]),
            .lut_out (lut_out[j])
        );
    end

endmodule

// File: tb/tb_lut_cluster.sv
// Randomized bench for lut_cluster with a queue-based chain model.
module tb_lut_cluster;

    localparam int K  = 5;
    localparam int N  = 4;
    localparam int SW = 33;
    localparam int CW = 132;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           cfg_start = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_bit = 1'b0;
    logic           cfg_ready;
    logic           cfg_done;
    logic           cfg_out;
    logic [N*K-1:0] lut_in = '0;
    logic [N-1:0]   lut_out;

    int n_vec = 0;
    int n_err = 0;
    bit mq[$];
    bit rb_exp = 1'b0;
    logic [CW-1:0] img_a, img_b, img_c, img_r;

    always #5 clock = ~clock;

    lut_cluster #(.K(K), .N(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_out   (cfg_out),
        .lut_in    (lut_in),
        .lut_out   (lut_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic exp_rb();
`ifdef LUT_CLUSTER_READBACK_EN
        return rb_exp;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [N*K-1:0] rnd_in();
        logic [31:0] r;
        r = $urandom;
        return r[N*K-1:0];
    endfunction

    function automatic logic rnd_bit();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < CW; i++) mq.push_back(1'b0);
        rb_exp = 1'b0;
    endtask

    // all tasks start and end 1 time unit after a rising edge
    task automatic do_reset(input int cyc);
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        repeat (cyc) @(posedge clock);
        model_reset();
        @(negedge clock);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_cfg_out", 32'(cfg_out), 32'd0);
        check("rst_lut_out", 32'(lut_out), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic idle(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            lut_in = rnd_in();
            @(negedge clock);
            check("idle_ready", 32'(cfg_ready), 32'd0);
            check("idle_done", 32'(cfg_done), 32'd0);
            check("idle_lut_out", 32'(lut_out), 32'd0);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load(input logic [CW-1:0] img, input int nbits, input bit gaps);
        int sent;
        int cyc;
        bit v;
        sent = 0;
        cyc  = 0;
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = rnd_bit();
        lut_in    = rnd_in();
        @(posedge clock);
        #1;
        cfg_start = 1'b0;
        while (sent < nbits) begin
            v = !(gaps && (cyc % 2 == 1));
            cfg_valid = v;
            cfg_bit   = v ? img[sent] : rnd_bit();
            lut_in    = rnd_in();
            @(negedge clock);
            check("load_ready", 32'(cfg_ready), 32'd1);
            check("load_done", 32'(cfg_done), 32'd0);
            check("load_lut_out", 32'(lut_out), 32'd0);
            check("readback", 32'(cfg_out), 32'(exp_rb()));
            @(posedge clock);
            if (v) begin
                rb_exp = mq.pop_front();
                mq.push_back(img[sent]);
                sent++;
            end
            #1;
            cyc++;
        end
        cfg_valid = 1'b0;
    endtask

    // entered in the first ACTIVE cycle
    task automatic run_active(input logic [CW-1:0] img, input int ncyc);
        logic [N-1:0] expv;
        logic [K-1:0] prev [N];
        logic [K-1:0] idx;
        logic [31:0]  tt;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                @(posedge clock);
                #1;
            end
            lut_in = rnd_in();
            if (c == 0) lut_in[K-1:0] = 5'b11111;
            if (c == 1) lut_in[K-1:0] = 5'b11110;
            @(negedge clock);
            for (int j = 0; j < N; j++) begin
                tt  = img[j*SW +: 32];
                idx = lut_in[j*K +: K];
                if (!img[j*SW + 32])  expv[j] = tt[idx];
                else if (c == 0)      expv[j] = 1'b0;
                else                  expv[j] = tt[prev[j]];
                prev[j] = idx;
            end
            check("act_done", 32'(cfg_done), 32'd1);
            check("act_ready", 32'(cfg_ready), 32'd0);
            check("act_lut_out", 32'(lut_out), 32'(expv));
            check("act_cfg_out", 32'(cfg_out), 32'(exp_rb()));
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        model_reset();
        img_a = '0;
        img_a[31:0] = 32'h8000_0000;
        img_b = img_a;
        img_b[SW +: 32] = 32'hFFFF_FFFF;
        img_b[SW + 32]  = 1'b1;
        for (int i = 0; i < CW; i++) img_c[i] = rnd_bit();
        for (int i = 0; i < CW; i++) img_r[i] = rnd_bit();

        do_reset(2);
        idle(10);

        load(img_a, CW, 1'b0);
        run_active(img_a, 8);
        load(img_b, CW, 1'b0);
        run_active(img_b, 8);
        load(img_b, CW, 1'b1);
        run_active(img_b, 8);

        load(img_r, 50, 1'b0);
        do_reset(1);
        idle(3);
        load(img_a, CW, 1'b0);
        run_active(img_a, 8);

        load(img_r, 50, 1'b0);
        load(img_c, CW, 1'b1);
        run_active(img_c, 24);
        load(img_a, CW, 1'b0);
        run_active(img_a, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lut_cluster.md
LUT_CLUSTER -- requirements
Module: lut_cluster

Interface
REQ-001 Parameter K, default 5: LUT input count; each LUT holds 2^K truth-table bits.
REQ-002 Parameter N, default 4: number of LUTs in the cluster.
REQ-003 Derived constant SLICE_W = 2^K+1 (truth table + 1 mode bit); CFG_W = N*SLICE_W (132 at defaults).
REQ-004 clock  input  1  sole clock, rising-edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 cfg_start  input  1  one-cycle pulse that begins or restarts a configuration load.
REQ-007 cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-008 cfg_bit  input  1  serial configuration data.
REQ-009 cfg_ready  output  1  high while a load can accept bits.
REQ-010 cfg_done  output  1  high while the cluster is configured and active.
REQ-011 cfg_out  output  1  serial readback of the bit shifted out of the chain.
REQ-012 lut_in  input  N*K  LUT j uses bits [j*K +: K].
REQ-013 lut_out  output  N  bit j = output of LUT j.

Function
REQ-014 FSM states UNCONF, LOAD, ACTIVE; reset state UNCONF.
REQ-015 UNCONF->LOAD on cfg_start; ACTIVE->LOAD on cfg_start; LOAD->LOAD on cfg_start (bit counter cleared to 0, chain contents kept).
REQ-016 cfg_ready = 1 only in LOAD; a bit transfers when cfg_valid && cfg_ready, and cfg_start takes priority over a same-cycle transfer (bit dropped).
REQ-017 Each transfer shifts the chain right by one: cfg_bit enters index CFG_W-1, index 0 leaves; after CFG_W transfers the first bit sent sits at index 0.
REQ-018 The bit counter increments per transfer, width clog2(CFG_W+1); the transfer that makes it CFG_W moves the FSM to ACTIVE on that edge, so cfg_done = 1 from the next cycle.
REQ-019 Idle cycles (cfg_valid = 0) in LOAD leave the chain and counter unchanged; there is no timeout.
REQ-020 Chain layout: LUT j = slice [j*SLICE_W +: SLICE_W]; slice bit i < 2^K = truth-table entry i; slice bit 2^K = mode (0 combinational, 1 registered).
REQ-021 In ACTIVE, mode 0: lut_out[j] = table[lut_in_j] with zero latency.
REQ-022 In ACTIVE, mode 1: lut_out[j] = a flop loaded with table[lut_in_j] each rising edge, giving one cycle of latency.
REQ-023 In UNCONF and LOAD, every lut_out bit = 0 and every output flop is held at 0, so the first registered value after entering ACTIVE appears one cycle after ACTIVE.
REQ-024 cfg_done = 1 only in ACTIVE; it drops in the cycle after a cfg_start in ACTIVE.

Reset
REQ-025 reset_n low at a rising edge sets: FSM UNCONF, counter 0, chain all zeros, output flops 0, cfg_ready 0, cfg_done 0, cfg_out 0, lut_out 0.
REQ-026 Reset mid-load aborts the load; no partial configuration survives.

Configuration
REQ-027 Macro LUT_CLUSTER_READBACK_EN: when defined, cfg_out = registered copy of chain index 0 captured on each transfer, allowing the previous image to be read out during a reload.
REQ-028 Without the macro, cfg_out is tied to 0 and no readback register exists.

Structure
REQ-029 Package lut_cluster_pkg holds the FSM state enum and the SLICE_W/CFG_W and counter-width helper functions.
REQ-030 Sub-module lut_cell holds one K-input LUT plus mode-selected output flop; lut_cluster instantiates it N times, and the chain, counter and FSM live in lut_cluster.

Verification (K=5, N=4)
REQ-031 Reset, then no cfg_start for 10 cycles -> cfg_ready = 0, cfg_done = 0, lut_out = 4'b0000 throughout.
REQ-032 Load 132 bits with LUT0 table = 32'h8000_0000, mode 0, others 0 -> cfg_done = 1 in the cycle after bit 132 (0 after bit 131); lut_in[4:0] = 5'b11111 gives lut_out[0] = 1 in the same cycle, and 5'b11110 gives 0.
REQ-033 Same image with LUT1 mode 1 and table = 32'hFFFF_FFFF -> lut_out[1] = 0 in the first ACTIVE cycle and 1 from the next cycle on.
REQ-034 Load with cfg_valid low on every other cycle -> ACTIVE reached after 132 transfers (264 cycles), and the image is identical to the gap-free load.
REQ-035 reset_n low after 50 transfers -> UNCONF, chain zero; a fresh 132-bit load then behaves as in REQ-032. A cfg_start after 50 transfers restarts the count and needs 132 more.
REQ-036 With LUT_CLUSTER_READBACK_EN, reload a second image -> the cfg_out sequence over the 132 transfers equals the first image, index 0 first.
